// File: rtl/tetris_board_writer.sv
// tetris_board_writer: spawns tetrominoes into the 10x20 board RAM during vblank, with collision check and full clear.
module tetris_board_writer #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vblank,
    input  logic              piece_valid,
    output logic              piece_ready,
    input  logic [2:0]        piece_type,
    input  logic [3:0]        piece_x,
    input  logic [4:0]        piece_y,
    input  logic              clear_req,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        wr_data,
    output logic              done,
    output logic [1:0]        status
);
    typedef enum logic [2:0] {IDLE, WAIT_VB, CHECK, EVAL, WRITE, CLEAR, DONE} state_t;
    // one octal digit per cell, cell 3 first: digit = {dy, dx[1:0]}
    localparam logic [11:0] SHAPES [8] = '{12'o3210, 12'o5410, 12'o5210, 12'o5421,
                                          12'o6510, 12'o6540, 12'o6542, 12'o0000};
    localparam logic [4:0]        X_MAX = 5'(BOARD_W - 1);
    localparam logic [5:0]        Y_MAX = 6'(BOARD_H - 1);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(BOARD_W * BOARD_H - 1);

    state_t            state;
    logic [2:0]        ptype;
    logic [3:0]        px;
    logic [4:0]        py;
    logic              clr;
    logic              coll;
    logic [1:0]        k;
    logic [11:0]       shape;
    logic [4:0]        cx   [4];
    logic [5:0]        cy   [4];
    logic [ADDR_W-1:0] addr [4];
    logic [3:0]        bad;
    logic              oob;

    assign shape = SHAPES[ptype];

    for (genvar i = 0; i < 4; i++) begin : g_cell
        assign cx[i]   = {1'b0, px} + {3'b0, shape[3*i +: 2]};
        assign cy[i]   = {1'b0, py} + {5'b0, shape[3*i+2]};
        assign addr[i] = ADDR_W'(cy[i]) * ADDR_W'(BOARD_W) + ADDR_W'(cx[i]);
        assign bad[i]  = (cx[i] > X_MAX) || (cy[i] > Y_MAX);
    end

    assign oob         = (ptype == 3'd7) || (|bad);
    assign piece_ready = (state == IDLE) && !clear_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptype   <= '0;
            px      <= '0;
            py      <= '0;
            clr     <= 1'b0;
            coll    <= 1'b0;
            k       <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
            status  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        clr   <= 1'b1;
                        state <= WAIT_VB;
                    end else if (piece_valid) begin
                        clr   <= 1'b0;
                        ptype <= piece_type;
                        px    <= piece_x;
                        py    <= piece_y;
                        state <= WAIT_VB;
                    end
                end
                WAIT_VB: begin
                    if (clr) begin
                        if (vblank) begin
                            wr_en   <= 1'b1;
                            wr_addr <= '0;
                            wr_data <= '0;
                            state   <= CLEAR;
                        end
                    end else if (oob) begin
                        done   <= 1'b1;
                        status <= 2'b10;
                        state  <= DONE;
                    end else if (vblank) begin
                        rd_en   <= 1'b1;
                        rd_addr <= addr[0];
                        k       <= '0;
                        coll    <= 1'b0;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    // read data trails the address by one cycle, so cycle 0 carries nothing
                    coll <= coll | ((k != 2'd0) && (rd_data != 3'd0));
                    if (k == 2'd3) begin
                        rd_en <= 1'b0;
                        state <= EVAL;
                    end else begin
                        rd_addr <= addr[k + 2'd1];
                        k       <= k + 2'd1;
                    end
                end
                EVAL: begin
                    if (coll || (rd_data != 3'd0)) begin
                        done   <= 1'b1;
                        status <= 2'b01;
                        state  <= DONE;
                    end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr[0];
                        wr_data <= ptype + 3'd1;
                        k       <= '0;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (k == 2'd3) begin
                        wr_en  <= 1'b0;
                        done   <= 1'b1;
                        status <= 2'b00;
                        state  <= DONE;
                    end else begin
                        wr_addr <= addr[k + 2'd1];
                        k       <= k + 2'd1;
                    end
                end
                CLEAR: begin
                    if (wr_addr == LAST) begin
                        wr_en  <= 1'b0;
                        done   <= 1'b1;
                        status <= 2'b11;
                        state  <= DONE;
                    end else begin
                        wr_addr <= wr_addr + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tetris_board_writer.sv
// tb_tetris_board_writer: directed bench for tetris_board_writer with a behavioural board RAM.
module tb_tetris_board_writer;
    logic       clk = 1'b0, rst = 1'b0, vblank = 1'b1, piece_valid = 1'b0, clear_req = 1'b0;
    logic [2:0] piece_type = '0;
    logic [3:0] piece_x = '0;
    logic [4:0] piece_y = '0;
    logic       piece_ready, rd_en, wr_en, done;
    logic [7:0] rd_addr, wr_addr;
    logic [2:0] rd_data = '0, wr_data;
    logic [1:0] status;
    logic [2:0] ram [0:255] = '{default: 3'd0};

    int cyc = 0, ncmp = 0, nfail = 0;
    int wn = 0, rn = 0, both = 0;
    int waddr [1024], wdat [1024], wcyc [1024], raddr [1024], rcyc [1024];
    int t0, td, w0, r0, rc, bad;
    int exp_t [4] = '{3, 4, 5, 14};
    int exp_o [4] = '{188, 189, 198, 199};
    int exp_z [4] = '{105, 106, 116, 117};

    tetris_board_writer dut (
        .clk(clk), .rst(rst), .vblank(vblank), .piece_valid(piece_valid),
        .piece_ready(piece_ready), .piece_type(piece_type), .piece_x(piece_x),
        .piece_y(piece_y), .clear_req(clear_req), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .status(status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_en) ram[wr_addr] <= wr_data;
        if (rd_en) rd_data <= ram[rd_addr];
    end

    always @(negedge clk) begin
        if (wr_en) begin
            waddr[wn] = int'(wr_addr);
            wdat[wn]  = int'(wr_data);
            wcyc[wn]  = cyc;
            wn++;
        end
        if (rd_en) begin
            raddr[rn] = int'(rd_addr);
            rcyc[rn]  = cyc;
            rn++;
        end
        if (rd_en && wr_en) both++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] t, input logic [3:0] x, input logic [4:0] y);
        step();
        piece_type  = t;
        piece_x     = x;
        piece_y     = y;
        piece_valid = 1'b1;
        t0 = cyc;
        w0 = wn;
        r0 = rn;
        step();
        piece_valid = 1'b0;
    endtask

    task automatic wait_done();
        rc = 0;
        for (int i = 0; i < 400 && done !== 1'b1; i++) begin
            if (piece_ready) rc++;
            step();
        end
        td = (done === 1'b1) ? cyc : -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, piece_ready, 1);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_status"}, status, 0);
    endtask

    initial begin
        #1;
        check_reset_outputs("reset");
        step();
        rst = 1'b1;

        // T piece at (3,0) on an empty board
        issue(3'd2, 4'd3, 5'd0);
        wait_done();
        check("t_done_lat", td - t0, 11);
        check("t_status", status, 2'b00);
        check("t_nreads", rn - r0, 4);
        check("t_first_rd", rcyc[r0] - t0, 2);
        check("t_nwrites", wn - w0, 4);
        check("t_first_wr", wcyc[w0] - t0, 7);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t_raddr%0d", i), raddr[r0+i], exp_t[i]);
            check($sformatf("t_waddr%0d", i), waddr[w0+i], exp_t[i]);
            check($sformatf("t_wdata%0d", i), wdat[w0+i], 3);
        end
        check("t_ready_in_done", piece_ready, 0);
        step();
        check("t_done_pulse", done, 0);
        check("t_ready_back", piece_ready, 1);

        // same T piece again collides
        issue(3'd2, 4'd3, 5'd0);
        wait_done();
        check("coll_done_lat", td - t0, 7);
        check("coll_status", status, 2'b01);
        check("coll_nreads", rn - r0, 4);
        check("coll_nwrites", wn - w0, 0);

        // illegal type 7
        issue(3'd7, 4'd0, 5'd0);
        wait_done();
        check("ill_done_lat", td - t0, 2);
        check("ill_status", status, 2'b10);
        check("ill_nreads", rn - r0, 0);

        // I piece at x=7 runs off the right edge
        issue(3'd0, 4'd7, 5'd5);
        wait_done();
        check("oob_done_lat", td - t0, 2);
        check("oob_status", status, 2'b10);
        check("oob_nreads", rn - r0, 0);
        check("oob_nwrites", wn - w0, 0);

        // O piece in the bottom-right corner waits for vblank
        step();
        vblank = 1'b0;
        issue(3'd1, 4'd8, 5'd18);
        repeat (50) step();
        check("vb_no_reads", rn - r0, 0);
        check("vb_no_writes", wn - w0, 0);
        check("vb_no_done", done, 0);
        vblank = 1'b1;
        wait_done();
        check("vb_status", status, 2'b00);
        check("vb_nwrites", wn - w0, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("vb_waddr%0d", i), waddr[w0+i], exp_o[i]);
            check($sformatf("vb_wdata%0d", i), wdat[w0+i], 2);
        end

        // clear and spawn together: clear wins
        step();
        step();
        clear_req   = 1'b1;
        piece_valid = 1'b1;
        piece_type  = 3'd1;
        t0 = cyc;
        w0 = wn;
        r0 = rn;
        #1;
        check("clr_ready_drop", piece_ready, 0);
        step();
        clear_req   = 1'b0;
        piece_valid = 1'b0;
        wait_done();
        check("clr_done_lat", td - t0, 202);
        check("clr_status", status, 2'b11);
        check("clr_ready_low", rc, 0);
        check("clr_nwrites", wn - w0, 200);
        check("clr_nreads", rn - r0, 0);
        bad = 0;
        for (int i = 0; i < 200; i++)
            if (waddr[w0+i] != i || wdat[w0+i] != 0) bad++;
        check("clr_write_seq", bad, 0);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (ram[i] != 3'd0) bad++;
        check("clr_ram_empty", bad, 0);

        // reset in the middle of writing an L piece at (0,0)
        issue(3'd6, 4'd0, 5'd0);
        while (cyc < t0 + 8) step();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        check("midrst_nwrites", wn - w0, 2);
        check("midrst_ram2", ram[2], 7);
        check("midrst_ram10", ram[10], 7);
        check("midrst_ram11", ram[11], 0);
        step();
        rst = 1'b1;

        // Z piece after the reset proceeds normally
        issue(3'd4, 4'd5, 5'd10);
        wait_done();
        check("z_done_lat", td - t0, 11);
        check("z_status", status, 2'b00);
        check("z_nwrites", wn - w0, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("z_waddr%0d", i), waddr[w0+i], exp_z[i]);
            check($sformatf("z_wdata%0d", i), wdat[w0+i], 5);
        end
        step();
        check("rd_wr_overlap", both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/tetris_board_writer.md
Name: tetris_board_writer

Overview:
- Write-side counterpart to the display path. The display path reads the board RAM and maps cells to pixels; this block fills that RAM.
- Accepts a spawn request (tetromino type from the random generator plus an anchor position) over a valid/ready handshake. It bounds-checks the piece, reads the four target cells to detect collision, and writes the piece colour into the 10x20 board RAM only during vertical blanking.
- Also supports a full board clear.
- Runs on the 25 MHz pixel clock, alongside the VGA controller.

Parameters:
- BOARD_W, 10, board columns
- BOARD_H, 20, board rows
- ADDR_W, 8, board RAM address width (BOARD_W*BOARD_H <= 2^ADDR_W)

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  asynchronous, active-low reset
- vblank  in  1  high during vertical blanking (from vga_controller timing)
- piece_valid  in  1  spawn request valid
- piece_ready  out  1  high only in IDLE; transfer on piece_valid && piece_ready
- piece_type  in  3  0=I 1=O 2=T 3=S 4=Z 5=J 6=L; 7 is illegal
- piece_x  in  4  anchor column
- piece_y  in  5  anchor row (row 0 at top)
- clear_req  in  1  board clear request, sampled in IDLE
- rd_en  out  1  board RAM read enable
- rd_addr  out  ADDR_W  read address
- rd_data  in  3  cell contents, valid 1 cycle after rd_en; 0 = empty
- wr_en  out  1  board RAM write enable
- wr_addr  out  ADDR_W  write address
- wr_data  out  3  colour written
- done  out  1  1-cycle pulse when an operation ends
- status  out  2  00 placed, 01 collision, 10 out-of-bounds/illegal, 11 cleared; held until next done

Behaviour:
- Reset (async, rst=0) forces:
  - state IDLE
  - piece_ready=1
  - rd_en=0, wr_en=0, done=0
  - rd_addr=0, wr_addr=0, wr_data=0
  - status=00
- Reset mid-operation aborts immediately. Cells already written stay in the RAM.
- States: IDLE, WAIT_VB, CHECK, EVAL, WRITE, CLEAR, DONE.
- IDLE:
  - clear_req has priority over piece_valid. clear_req=1 -> WAIT_VB with the clear flag set; piece_ready is dropped that cycle.
  - Otherwise, on a handshake, latch type/x/y -> WAIT_VB.
- WAIT_VB:
  - Illegal type (7) or any cell out of bounds -> DONE with status 10, without waiting for vblank.
  - Otherwise stay until vblank=1, then go to CLEAR (clear flag) or CHECK. If vblank is already high, advance the next cycle.
- Cell offsets (dx,dy), cells 0..3 in this order:
  - I: (0,0)(1,0)(2,0)(3,0)
  - O: (0,0)(1,0)(0,1)(1,1)
  - T: (0,0)(1,0)(2,0)(1,1)
  - S: (1,0)(2,0)(0,1)(1,1)
  - Z: (0,0)(1,0)(1,1)(2,1)
  - J: (0,0)(0,1)(1,1)(2,1)
  - L: (2,0)(0,1)(1,1)(2,1)
- Bounds rule: x+dx <= BOARD_W-1 and y+dy <= BOARD_H-1, with no wrap-around. Sums are computed 1 bit wider than the operands.
- Cell address = (y+dy)*BOARD_W + (x+dx).
- CHECK: 4 cycles, rd_en=1, rd_addr = cell k in cycle k. Each returned rd_data is ORed into a collision flag.
- EVAL: 1 cycle to capture rd_data for cell 3. Collision -> DONE with status 01. Otherwise -> WRITE.
- WRITE: 4 cycles, wr_en=1, wr_addr = cell k, wr_data = type+1 (1..7) -> DONE with status 00.
- CLEAR: BOARD_W*BOARD_H cycles, wr_en=1, wr_addr 0..199 ascending, wr_data=0 -> DONE with status 11.
- DONE: done=1 for one cycle -> IDLE. piece_ready returns to 1 the following cycle.
- Latency with vblank=1 throughout and handshake at cycle T:
  - WAIT_VB at T+1
  - reads at T+2..T+5
  - EVAL at T+6
  - writes at T+7..T+10
  - done at T+11
- Clear latency: done at T+2+200.
- vblank falling during CHECK/WRITE/CLEAR does not pause the operation. The vblank window (45 lines x 800 clocks) bounds the worst case.
- rd_en and wr_en are never high in the same cycle.
- piece_valid held during a busy operation is ignored until the next IDLE.

Test Plan:
- Reset, empty RAM, vblank=1, T piece at x=3, y=0 -> writes to addr 3,4,5,14 with data 3; done at handshake+11; status 00.
- Repeat the same T piece on the same board -> reads see nonzero; no wr_en; status 01.
- I piece at x=7, y=5 (x+3=10) -> no rd_en/wr_en; immediate done; status 10. Type 7 -> also status 10.
- vblank=0 for 50 cycles after an O piece handshake at x=8, y=18 -> no RAM access until vblank rises; then writes to 188,189,198,199 with data 2.
- clear_req and piece_valid asserted together in IDLE -> clear wins: 200 writes of 0 to addr 0..199; status 11; piece_ready low throughout.
- rst=0 asserted mid-WRITE after 2 writes -> wr_en drops asynchronously; outputs return to reset values; the next request proceeds normally.
